// File: rtl/tnn_seq_threshold_neuron.sv
`default_nettype none
// ============================================================================
//  Module      : tnn_seq_threshold_neuron
//  Description : Sequential sum-and-threshold neuron; accumulates NUM_TERMS
//                operands per sample and emits (sum > threshold) plus the sum.
//  Revision    : 1.0 - initial release
// ============================================================================
module tnn_seq_threshold_neuron #(
    parameter int IN_W       = 3,
    parameter int NUM_TERMS  = 2,
    parameter int THR_W      = 3,
    parameter int TRUNC_LSBS = 0,
    localparam int SUM_W     = IN_W + $clog2(NUM_TERMS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [THR_W-1:0] thr_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [SUM_W-1:0] out_sum
);

    localparam int c_CNT_W = $clog2(NUM_TERMS);
    localparam int c_CMP_W = (SUM_W > THR_W) ? SUM_W : THR_W;

    typedef enum logic [0:0] {
        S_ACC  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_CNT_W-1:0]  r_count;
    logic [SUM_W-1:0]    r_acc;
    logic [THR_W-1:0]    r_thr;
    logic                r_out_bit;
    logic [SUM_W-1:0]    r_out_sum;

    logic [IN_W-1:0]     w_term;
    logic [SUM_W-1:0]    w_sum;
    logic                w_accept;
    logic                w_last;
    logic                w_gt;

    generate
        if (TRUNC_LSBS == 0) begin : g_exact
            assign w_term = in_data;
        end else begin : g_trunc
            assign w_term = {in_data[IN_W-1:TRUNC_LSBS], {TRUNC_LSBS{1'b0}}};
        end
    endgenerate

    // SUM_W covers NUM_TERMS * (2^IN_W - 1), so this add cannot wrap.
    assign w_sum    = r_acc + SUM_W'(w_term);
    assign w_gt     = c_CMP_W'(w_sum) > c_CMP_W'(r_thr);
    assign w_last   = (r_count == c_CNT_W'(NUM_TERMS - 1));
    assign in_ready = (r_state == S_ACC);
    assign w_accept = in_valid && in_ready && !clear_i;

    assign out_valid = (r_state == S_HOLD);
    assign out_bit   = r_out_bit;
    assign out_sum   = r_out_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear_i) begin
            w_state_next = S_ACC;
        end else begin
            case (r_state)
                S_ACC:   if (w_accept && w_last) w_state_next = S_HOLD;
                S_HOLD:  if (out_ready)          w_state_next = S_ACC;
                default: w_state_next = S_ACC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_acc     <= '0;
            r_thr     <= '0;
            r_out_bit <= 1'b0;
            r_out_sum <= '0;
        end else if (clear_i) begin
            r_count <= '0;
            r_acc   <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_out_sum <= w_sum;
                r_out_bit <= w_gt;
                r_count   <= '0;
            end else if (r_count == '0) begin
                // First beat starts a fresh sample and captures its threshold.
                r_acc   <= SUM_W'(w_term);
                r_thr   <= thr_i;
                r_count <= c_CNT_W'(1);
            end else begin
                r_acc   <= w_sum;
                r_count <= r_count + c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tnn_seq_threshold_neuron.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tnn_seq_threshold_neuron
//  Description : Directed self-checking bench for tnn_seq_threshold_neuron.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tnn_seq_threshold_neuron;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         n_checks = 0;
    int         n_pass   = 0;

    // Default-parameter instance
    logic       clear_i = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_data = '0;
    logic [2:0] thr_i = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_bit;
    logic [3:0] out_sum;

    // Four-term instances (truncating and exact) sharing one input stream
    logic       wclear = 1'b0;
    logic       win_valid = 1'b0;
    logic [2:0] win_data = '0;
    logic [4:0] wthr = '0;
    logic       wout_ready = 1'b0;
    logic       w1_in_ready, w1_out_valid, w1_out_bit;
    logic [4:0] w1_out_sum;
    logic       w2_in_ready, w2_out_valid, w2_out_bit;
    logic [4:0] w2_out_sum;

    always #5 clk = ~clk;

    tnn_seq_threshold_neuron dut (
        .clk(clk), .rst(rst), .clear_i(clear_i),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .thr_i(thr_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .out_sum(out_sum)
    );

    tnn_seq_threshold_neuron #(.IN_W(3), .NUM_TERMS(4), .THR_W(5), .TRUNC_LSBS(1)) dut_trunc (
        .clk(clk), .rst(rst), .clear_i(wclear),
        .in_valid(win_valid), .in_ready(w1_in_ready), .in_data(win_data), .thr_i(wthr),
        .out_valid(w1_out_valid), .out_ready(wout_ready), .out_bit(w1_out_bit), .out_sum(w1_out_sum)
    );

    tnn_seq_threshold_neuron #(.IN_W(3), .NUM_TERMS(4), .THR_W(5), .TRUNC_LSBS(0)) dut_exact (
        .clk(clk), .rst(rst), .clear_i(wclear),
        .in_valid(win_valid), .in_ready(w2_in_ready), .in_data(win_data), .thr_i(wthr),
        .out_valid(w2_out_valid), .out_ready(wout_ready), .out_bit(w2_out_bit), .out_sum(w2_out_sum)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [2:0] d, input logic [2:0] t);
        int k = 0;
        in_valid = 1'b1;
        in_data  = d;
        thr_i    = t;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL beat_timeout: in_ready=%0b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic send_wbeat(input logic [2:0] d, input logic [4:0] t);
        int k = 0;
        win_valid = 1'b1;
        win_data  = d;
        wthr      = t;
        while (!w1_in_ready && k < 20) begin
            tick();
            k++;
        end
        if (!w1_in_ready) begin
            n_checks++;
            $display("FAIL wbeat_timeout: in_ready=%0b required 1", w1_in_ready);
        end
        tick();
        win_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if ({in_ready, out_valid, out_bit, out_sum} !== {1'b1, 1'b0, 1'b0, 4'd0})
            $display("FAIL reset_state: rdy/vld/bit/sum=%0b/%0b/%0b/%0d required 1/0/0/0",
                     in_ready, out_valid, out_bit, out_sum);
        else n_pass++;
    endtask

    task automatic test_basic();
        send_beat(3'd3, 3'd6);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %0b required 0", out_valid);
        else n_pass++;
        send_beat(3'd4, 3'd6);
        n_checks++;
        if ({out_valid, out_bit, out_sum} !== {1'b1, 1'b1, 4'd7})
            $display("FAIL basic_3_4: vld/bit/sum=%0b/%0b/%0d required 1/1/7", out_valid, out_bit, out_sum);
        else n_pass++;
        consume();
        n_checks++;
        if ({out_valid, in_ready, out_bit, out_sum} !== {1'b0, 1'b1, 1'b1, 4'd7})
            $display("FAIL basic_consume: vld/rdy/bit/sum=%0b/%0b/%0b/%0d required 0/1/1/7",
                     out_valid, in_ready, out_bit, out_sum);
        else n_pass++;
    endtask

    task automatic test_equality();
        send_beat(3'd3, 3'd6);
        send_beat(3'd3, 3'd6);
        n_checks++;
        if ({out_valid, out_bit, out_sum} !== {1'b1, 1'b0, 4'd6})
            $display("FAIL equal_3_3_6: vld/bit/sum=%0b/%0b/%0d required 1/0/6", out_valid, out_bit, out_sum);
        else n_pass++;
        consume();
        send_beat(3'd7, 3'd7);
        send_beat(3'd7, 3'd7);
        n_checks++;
        if ({out_valid, out_bit, out_sum} !== {1'b1, 1'b1, 4'd14})
            $display("FAIL max_7_7_7: vld/bit/sum=%0b/%0b/%0d required 1/1/14", out_valid, out_bit, out_sum);
        else n_pass++;
        consume();
    endtask

    task automatic test_sweep();
        logic [3:0] exp_sum;
        logic       exp_bit;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                for (int c = 0; c < 8; c++) begin
                    exp_sum = 4'(a + b);
                    exp_bit = ((a + b) > c);
                    send_beat(3'(a), 3'(c));
                    send_beat(3'(b), 3'(7 - c));
                    n_checks++;
                    if ({out_valid, out_bit, out_sum} !== {1'b1, exp_bit, exp_sum})
                        $display("FAIL sweep a=%0d b=%0d c=%0d: vld/bit/sum=%0b/%0b/%0d required 1/%0b/%0d",
                                 a, b, c, out_valid, out_bit, out_sum, exp_bit, exp_sum);
                    else n_pass++;
                    consume();
                end
            end
        end
    endtask

    task automatic test_backpressure();
        send_beat(3'd3, 3'd6);
        send_beat(3'd4, 3'd7);
        in_valid  = 1'b1;
        in_data   = 3'd5;
        thr_i     = 3'd6;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({in_ready, out_valid, out_bit, out_sum} !== {1'b0, 1'b1, 1'b1, 4'd7})
                $display("FAIL backpressure_hold cyc=%0d: rdy/vld/bit/sum=%0b/%0b/%0b/%0d required 0/1/1/7",
                         i, in_ready, out_valid, out_bit, out_sum);
            else n_pass++;
        end
        consume();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL backpressure_release: vld/rdy=%0b/%0b required 0/1", out_valid, in_ready);
        else n_pass++;
        tick();
        in_data = 3'd1;
        thr_i   = 3'd0;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_bit, out_sum} !== {1'b1, 1'b0, 4'd6})
            $display("FAIL backpressure_next: vld/bit/sum=%0b/%0b/%0d required 1/0/6", out_valid, out_bit, out_sum);
        else n_pass++;
        consume();
    endtask

    task automatic test_clear();
        send_beat(3'd6, 3'd0);
        clear_i  = 1'b1;
        in_valid = 1'b1;
        in_data  = 3'd7;
        tick();
        clear_i  = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL clear_partial: rdy/vld=%0b/%0b required 1/0", in_ready, out_valid);
        else n_pass++;
        send_beat(3'd1, 3'd1);
        send_beat(3'd1, 3'd1);
        n_checks++;
        if ({out_valid, out_bit, out_sum} !== {1'b1, 1'b1, 4'd2})
            $display("FAIL clear_then_1_1: vld/bit/sum=%0b/%0b/%0d required 1/1/2", out_valid, out_bit, out_sum);
        else n_pass++;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL clear_hold: vld/rdy=%0b/%0b required 0/1", out_valid, in_ready);
        else n_pass++;
        send_beat(3'd1, 3'd2);
        send_beat(3'd2, 3'd2);
        n_checks++;
        if ({out_valid, out_bit, out_sum} !== {1'b1, 1'b1, 4'd3})
            $display("FAIL clear_recover: vld/bit/sum=%0b/%0b/%0d required 1/1/3", out_valid, out_bit, out_sum);
        else n_pass++;
        consume();
    endtask

    task automatic test_rst_hold();
        send_beat(3'd5, 3'd1);
        send_beat(3'd5, 3'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({out_valid, out_bit, out_sum, in_ready} !== {1'b0, 1'b0, 4'd0, 1'b1})
            $display("FAIL rst_in_hold: vld/bit/sum/rdy=%0b/%0b/%0d/%0b required 0/0/0/1",
                     out_valid, out_bit, out_sum, in_ready);
        else n_pass++;
        send_beat(3'd2, 3'd4);
        send_beat(3'd3, 3'd4);
        n_checks++;
        if ({out_valid, out_bit, out_sum} !== {1'b1, 1'b1, 4'd5})
            $display("FAIL rst_recover: vld/bit/sum=%0b/%0b/%0d required 1/1/5", out_valid, out_bit, out_sum);
        else n_pass++;
        consume();
    endtask

    task automatic test_wide();
        logic [4:0] thr_list [2];
        logic       exp_bit1 [2];
        thr_list[0] = 5'd12; exp_bit1[0] = 1'b0;
        thr_list[1] = 5'd11; exp_bit1[1] = 1'b1;
        for (int s = 0; s < 2; s++) begin
            send_wbeat(3'd1, thr_list[s]);
            send_wbeat(3'd3, 5'd0);
            send_wbeat(3'd5, 5'd31);
            n_checks++;
            if (w1_out_valid !== 1'b0) $display("FAIL wide_early_valid: got %0b required 0", w1_out_valid);
            else n_pass++;
            send_wbeat(3'd7, 5'd0);
            n_checks++;
            if ({w1_out_valid, w1_out_bit, w1_out_sum} !== {1'b1, exp_bit1[s], 5'd12})
                $display("FAIL wide_trunc thr=%0d: vld/bit/sum=%0b/%0b/%0d required 1/%0b/12",
                         thr_list[s], w1_out_valid, w1_out_bit, w1_out_sum, exp_bit1[s]);
            else n_pass++;
            n_checks++;
            if ({w2_out_valid, w2_out_bit, w2_out_sum} !== {1'b1, 1'b1, 5'd16})
                $display("FAIL wide_exact thr=%0d: vld/bit/sum=%0b/%0b/%0d required 1/1/16",
                         thr_list[s], w2_out_valid, w2_out_bit, w2_out_sum);
            else n_pass++;
            wout_ready = 1'b1;
            tick();
            wout_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_equality();
        test_backpressure();
        test_clear();
        test_rst_hold();
        test_wide();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tnn_seq_threshold_neuron.md
Name: tnn_seq_threshold_neuron

Overview:
Parametrised, sequential successor to the 3-bit two-operand sum-and-threshold neuron cells in the TNN arithmetic library. Accepts NUM_TERMS unsigned operands of IN_W bits, one per cycle, over a valid/ready stream. Accumulates them exactly, or with optional LSB truncation for approximate variants. Emits one registered decision bit, (sum > threshold), plus the sum, over a second valid/ready handshake. Sits between the layer input buffer and the activation collector of a TNN layer.

Parameters:
IN_W, 3, operand width in bits (>=1)
NUM_TERMS, 2, operands per sample (>=2)
THR_W, 3, threshold width in bits (>=1)
TRUNC_LSBS, 0, low operand bits forced to 0 before accumulation (0..IN_W-1); 0 = exact
Derived: SUM_W = IN_W + clog2(NUM_TERMS); CMP_W = max(SUM_W, THR_W)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
clear_i  in  1  synchronous flush of partial or pending sample
in_valid  in  1  operand beat valid
in_ready  out  1  operand beat accepted when in_valid & in_ready
in_data  in  IN_W  unsigned operand
thr_i  in  THR_W  unsigned threshold, sampled on first beat of a sample only
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid & out_ready
out_bit  out  1  registered decision: sum > threshold
out_sum  out  SUM_W  registered (truncated) sum

Behaviour:
- States: ACC (collecting beats), HOLD (result presented). Reset state ACC.
- Reset values: state=ACC, beat count=0, accumulator=0, latched threshold=0, out_valid=0, out_bit=0, out_sum=0. in_ready=1 in the cycle after reset.
- in_ready = (state==ACC); it is a decode of registered state only, with no combinational path from out_ready.
- Operand term = in_data with its low TRUNC_LSBS bits zeroed.
- ACC, beat accepted with count==0: acc<=term, thr_latched<=thr_i, count<=1.
- ACC, beat accepted with 0<count<NUM_TERMS-1: acc<=acc+term, count++. thr_i is ignored.
- ACC, beat accepted with count==NUM_TERMS-1:
  - out_sum<=acc+term
  - out_bit<=((acc+term) > thr_latched), both sides zero-extended to CMP_W; equality gives 0
  - out_valid<=1, state<=HOLD, count<=0
  - Latency: result visible 1 cycle after the last beat handshake.
- ACC with in_valid=0: no state change.
- HOLD: out_valid=1; out_bit and out_sum stay stable until the handshake; in_ready=0.
- HOLD with out_ready=1: out_valid<=0, state<=ACC. The next sample's first beat is accepted at the earliest in the following cycle (no bypass). out_bit and out_sum keep their last values after out_valid drops.
- The accumulator never overflows. SUM_W is exact for NUM_TERMS x (2^IN_W - 1). No saturation logic.
- clear_i=1: state<=ACC, count<=0, acc<=0, out_valid<=0. Any pending HOLD result is dropped. A beat presented in the same cycle is not accepted; in_ready is still 1 if the state was ACC, but the clear wins.
- Priority: rst > clear_i > handshakes.
- rst mid-sample or in HOLD returns every register to its reset value. Any partial sum is lost.
- out_valid must not drop without out_ready, except on rst or clear_i.

Test Plan:
- Defaults: beats 3,4 with thr_i=6 on beat 0 -> 1 cycle after beat 1: out_valid=1, out_sum=7, out_bit=1.
- Defaults: beats 3,3 with thr_i=6 -> out_sum=6, out_bit=0 (equality is not greater). Beats 7,7 with thr_i=7 -> out_sum=14, out_bit=1. Exhaustive sweep over all 512 (a,b,c) triples against the reference model (a+b)>c.
- Backpressure: with a result pending, hold out_ready=0 for 5 cycles while in_valid=1 with in_data=5 -> in_ready=0 throughout, out_sum and out_bit stable. Then out_ready=1 -> out_valid drops and beat 5 is accepted the next cycle as beat 0. Also change thr_i during beat 1 and check the beat-0 value is used.
- clear_i after beat 0 (value 6): then beats 1,1 with thr_i=1 -> out_sum=2, out_bit=1 (the 6 is discarded). clear_i in HOLD -> out_valid=0 next cycle, in_ready=1.
- rst asserted in HOLD -> next cycle out_valid=0, out_bit=0, out_sum=0, in_ready=1; a following 2-beat sample completes normally.
- IN_W=3, NUM_TERMS=4, THR_W=5, TRUNC_LSBS=1: beats 1,3,5,7 with thr_i=12 -> out_sum=12, out_bit=0. Same beats with thr_i=11 -> out_bit=1. Same beats with TRUNC_LSBS=0 and thr_i=12 -> out_sum=16, out_bit=1.
